// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide,
// sign fix-up in a final cycle, one-cycle done strobe for the HI/LO enable.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  // state | meaning
  // IDLE  | waiting for start; hi/lo hold last result
  // RUN   | one multiply/divide iteration per cycle
  // FIX   | sign correction, result load, done strobe
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    opnd_q, opnd_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            b_zero_q, b_zero_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic [N-1:0]    mag_a, mag_b;
  logic [N:0]      add_sum;
  logic [N:0]      shifted;
  logic [N:0]      trial;
  logic [2*N-1:0]  prod;
  logic            signed_q;

  assign mag_a    = (~op[0] & operand_a[N-1]) ? -operand_a : operand_a;
  assign mag_b    = (~op[0] & operand_b[N-1]) ? -operand_b : operand_b;
  assign signed_q = ~op_q[0];

  // Multiply: low half of acc holds the remaining multiplier bits.
  assign add_sum = acc_q[0] ? ({1'b0, acc_q[2*N-1:N]} + {1'b0, opnd_q})
                            : {1'b0, acc_q[2*N-1:N]};
  // Divide: low half of acc shifts the dividend out and the quotient in.
  assign shifted = {rem_q, acc_q[N-1]};
  assign trial   = shifted - {1'b0, opnd_q};
  assign prod    = (signed_q & (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = op;
          a_d      = operand_a;
          sign_a_d = ~op[0] & operand_a[N-1];
          sign_b_d = ~op[0] & operand_b[N-1];
          b_zero_d = (operand_b == '0);
          rem_d    = '0;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{N{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{N{1'b0}}, mag_b};
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = FIX;
        end
        if (op_q[1]) begin
          if (!trial[N]) begin
            rem_d = trial[N-1:0];
            acc_d = {acc_q[2*N-1:N], acc_q[N-2:0], 1'b1};
          end else begin
            rem_d = shifted[N-1:0];
            acc_d = {acc_q[2*N-1:N], acc_q[N-2:0], 1'b0};
          end
        end else begin
          acc_d = {add_sum, acc_q[N-1:1]};
        end
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        if (op_q[1]) begin
          if (b_zero_q) begin
            // Divide by zero reports the original dividend, not its magnitude.
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = (signed_q & sign_a_q) ? -rem_q : rem_q;
            lo_d = (signed_q & (sign_a_q ^ sign_b_q)) ? -acc_q[N-1:0]
                                                      : acc_q[N-1:0];
          end
        end else begin
          hi_d = prod[2*N-1:N];
          lo_d = prod[N-1:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks;
  int n_errors;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mult_div_unit #(.N(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and waits (bounded) for done, sampling on falling edges.
  // lat counts falling edges after the start-sampling edge up to the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bcnt, pulses;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0; start = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
    check("mult_latency", 64'(lat), 64'd34);
    check("mult_busy_cycles", 64'(bcnt), 64'd33);
    check("mult_busy_in_done", {63'd0, busy}, 64'd0);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("mult_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    do_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
    check("divu_latency", 64'(lat), 64'd34);
    check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    check("div_negb_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    do_op(OP_DIV, 32'h1234_5678, 32'd0, lat, bcnt);
    check("dbz_latency", 64'(lat), 64'd34);
    check("dbz_hilo", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    @(negedge clk);
    check("dbz_flag_hold", {63'd0, div_by_zero}, 64'd1);

    do_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, lat, bcnt);
    check("dbz_neg_hilo", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("div_ovf_dbz_clr", {63'd0, div_by_zero}, 64'd0);

    // start held high with operands churning during the first operation
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd10;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        op = 2'($urandom_range(0, 3));
        operand_a = $urandom;
        operand_b = $urandom;
      end
    end while (!done && lat < 100);
    check("b2b_first_latency", 64'(lat), 64'd34);
    check("b2b_first_hilo", {hi, lo}, 64'h0000_0000_0000_0064);
    op = OP_MULT; operand_a = 32'hFFFF_FFFE; operand_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", {63'd0, busy}, 64'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 64'(lat), 64'd34);
    check("b2b_second_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF2);

    // reset while the counter sits at 10
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    do_op(OP_MULTU, 32'd3, 32'd4, lat, bcnt);
    check("after_abort_latency", 64'(lat), 64'd34);
    check("after_abort_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
